// File: rtl/pvm_pkg.sv
// Shared types and helpers for the parametrised voting machine.
// Optional feature macro PVM_TOTAL_EN is consumed by the top level only.
package pvm_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, WAIT_REL} state_t;

  localparam int MAX_CAND        = 16;
  localparam int DEF_NUM_CAND    = 4;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_HOLD_CYCLES = 10;
  localparam int DEF_LED_W       = 8;

  function automatic logic is_onehot(input logic [MAX_CAND-1:0] v);
    return (v != '0) && ((v & (v - 16'd1)) == '0);
  endfunction

  // Ties resolve to the lowest-numbered candidate.
  function automatic logic [3:0] lowest_idx(input logic [MAX_CAND-1:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = MAX_CAND - 1; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/pvm_hold_timer.sv
// Hold qualifier: counts consecutive enabled cycles and flags the cycle on
// which the count reaches HOLD_CYCLES.
module pvm_hold_timer
  import pvm_pkg::*;
#(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic reached
);

  localparam int W = $clog2(HOLD_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(HOLD_CYCLES - 1);

  logic [W-1:0] hold_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      hold_cnt <= '0;
    else if (clr)    hold_cnt <= '0;
    else if (en)     hold_cnt <= hold_cnt + W'(1);
  end

  // Asserted during the cycle whose edge brings hold_cnt up to HOLD_CYCLES.
  assign reached = en && !clr && (hold_cnt == LAST);

endmodule

// File: rtl/param_voting_machine.sv
// NUM_CAND-button voting machine with hold qualifier, saturating tallies and
// display readback. Define PVM_TOTAL_EN to add the running `total` output.
module param_voting_machine
  import pvm_pkg::*;
#(
  parameter int NUM_CAND    = DEF_NUM_CAND,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int LED_W       = DEF_LED_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode,
  input  logic [NUM_CAND-1:0] button,
  output logic [LED_W-1:0]    led,
  output logic                vote_accepted,
  output logic                vote_rejected
`ifdef PVM_TOTAL_EN
  ,
  output logic [CNT_W+$clog2(NUM_CAND)-1:0] total
`endif
);

  localparam int IDX_W = $clog2(NUM_CAND);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_CAND-1:0] button_q;
  logic                mode_q;
  state_t              state, state_n;
  logic [IDX_W-1:0]    idx, cand, sel;
  logic [CNT_W-1:0]    tally [NUM_CAND];
  logic                clr, en, reached, accept, reject, load_idx, saturated;
  logic [LED_W-1:0]    led_n;

  assign sel       = IDX_W'(lowest_idx(MAX_CAND'(button_q)));
  assign cand      = (state == IDLE) ? sel : idx;
  assign saturated = (tally[cand] == CNT_MAX);

  pvm_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .en      (en),
    .reached (reached)
  );

  always_comb begin
    state_n  = state;
    clr      = 1'b1;
    en       = 1'b0;
    accept   = 1'b0;
    reject   = 1'b0;
    load_idx = 1'b0;
    unique case (state)
      IDLE: begin
        if (mode_q) begin
          state_n = WAIT_REL;
        end else if (is_onehot(MAX_CAND'(button_q))) begin
          clr      = 1'b0;
          en       = 1'b1;
          load_idx = 1'b1;
          state_n  = ARMED;
          if (reached) begin
            accept  = !saturated;
            reject  = saturated;
            state_n = WAIT_REL;
          end
        end else if (button_q != '0) begin
          reject  = 1'b1;
          state_n = WAIT_REL;
        end
      end
      ARMED: begin
        // Mode change wins over any simultaneous button activity.
        if (mode_q) begin
          state_n = WAIT_REL;
        end else if (button_q == (NUM_CAND'(1) << idx)) begin
          clr = 1'b0;
          en  = 1'b1;
          if (reached) begin
            accept  = !saturated;
            reject  = saturated;
            state_n = WAIT_REL;
          end
        end else if (button_q == '0) begin
          state_n = IDLE;
        end else begin
          reject  = 1'b1;
          state_n = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (button_q == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef PVM_TOTAL_EN
  localparam int TOT_W = CNT_W + $clog2(NUM_CAND);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      total <= '0;
    else if (accept) total <= total + TOT_W'(1);
  end
`endif

  always_comb begin
    led_n = '0;
    if (mode_q) begin
      if (button_q != '0) led_n = LED_W'(tally[sel]);
`ifdef PVM_TOTAL_EN
      else                led_n = LED_W'(total);
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      button_q      <= '0;
      mode_q        <= 1'b0;
      state         <= IDLE;
      idx           <= '0;
      vote_accepted <= 1'b0;
      vote_rejected <= 1'b0;
      led           <= '0;
      for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
    end else begin
      button_q      <= button;
      mode_q        <= mode;
      state         <= state_n;
      vote_accepted <= accept;
      vote_rejected <= reject;
      led           <= led_n;
      if (load_idx) idx <= cand;
      if (accept)   tally[cand] <= tally[cand] + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_param_voting_machine.sv
// Directed bench: a default instance and a CNT_W=2 instance share the stimulus.
// Build with PVM_TOTAL_EN defined to also exercise the `total` output.
module tb_param_voting_machine;

  logic       clk = 1'b0;
  logic       reset;
  logic       mode;
  logic [3:0] button;
  logic [7:0] led_a, led_b;
  logic       acc_a, rej_a, acc_b, rej_b;
`ifdef PVM_TOTAL_EN
  logic [9:0] total_a;
  logic [3:0] total_b;
`endif

  int total_n = 0;
  int bad_n   = 0;
  int edge_no = 0;
  int start_edge, first_acc, acc_n, rej_n, sacc_n, srej_n;

  always #5 clk = ~clk;

  param_voting_machine dut_a (
    .clk           (clk),
    .reset         (reset),
    .mode          (mode),
    .button        (button),
    .led           (led_a),
    .vote_accepted (acc_a),
    .vote_rejected (rej_a)
`ifdef PVM_TOTAL_EN
    ,
    .total         (total_a)
`endif
  );

  param_voting_machine #(.CNT_W(2)) dut_b (
    .clk           (clk),
    .reset         (reset),
    .mode          (mode),
    .button        (button),
    .led           (led_b),
    .vote_accepted (acc_b),
    .vote_rejected (rej_b)
`ifdef PVM_TOTAL_EN
    ,
    .total         (total_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_n++;
    assert (got === exp) else begin
      bad_n++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_no++;
    if (acc_a) begin
      acc_n++;
      if (first_acc < 0) first_acc = edge_no - start_edge - 1;
    end
    if (rej_a) rej_n++;
    if (acc_b) sacc_n++;
    if (rej_b) srej_n++;
  endtask

  task automatic clear_counts();
    start_edge = edge_no;
    first_acc  = -1;
    acc_n = 0; rej_n = 0; sacc_n = 0; srej_n = 0;
  endtask

  task automatic press(input logic [3:0] mask, input int n);
    button = mask;
    repeat (n) tick();
  endtask

  task automatic release_btn();
    button = 4'b0000;
    repeat (3) tick();
  endtask

  task automatic vote(input logic [3:0] mask);
    press(mask, 20);
    release_btn();
  endtask

  task automatic read(input string tag, input logic [3:0] mask,
                      input int exp_a, input int exp_b);
    mode   = 1'b1;
    button = mask;
    tick();
    tick();
    check({tag, "_a"}, 32'(led_a), exp_a);
    check({tag, "_b"}, 32'(led_b), exp_b);
    mode   = 1'b0;
    button = 4'b0000;
    repeat (3) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset  = 1'b0;
    mode   = 1'b0;
    button = 4'b0000;
    clear_counts();
    tick();
    tick();
    check("rst_led", 32'(led_a), 0);
    check("rst_acc", 32'(acc_a), 0);
    check("rst_rej", 32'(rej_a), 0);
    reset = 1'b1;
    tick();

    // Single vote on candidate 1 held for 200 ns
    clear_counts();
    vote(4'b0010);
    check("v1_acc_count", acc_n, 1);
    check("v1_latency", first_acc, 10);
    check("v1_rej_count", rej_n, 0);
    read("v1_tally1", 4'b0010, 1, 1);
    read("v1_tally2", 4'b0100, 0, 0);
    read("disp_none", 4'b0000, 0, 0);

    // Short press is discarded, full press counts
    clear_counts();
    press(4'b0100, 5);
    release_btn();
    check("short_acc", acc_n, 0);
    check("short_rej", rej_n, 0);
    read("short_tally2", 4'b0100, 0, 0);
    clear_counts();
    vote(4'b0100);
    check("v2_acc", acc_n, 1);
    read("v2_tally2", 4'b0100, 1, 1);

    // Multi-press rejected once; no vote until full release
    clear_counts();
    vote(4'b0110);
    check("multi_rej", rej_n, 1);
    check("multi_acc", acc_n, 0);
    read("multi_tally1", 4'b0010, 1, 1);
    read("multi_tally2", 4'b0100, 1, 1);
    clear_counts();
    press(4'b0110, 5);
    press(4'b0010, 20);
    release_btn();
    check("norel_acc", acc_n, 0);
    check("norel_rej", rej_n, 1);
    clear_counts();
    vote(4'b0010);
    check("revote_acc", acc_n, 1);
    read("revote_tally1", 4'b0010, 2, 2);

    // Reset mid-hold aborts and clears tallies
    clear_counts();
    press(4'b0001, 5);
    button = 4'b0000;
    reset  = 1'b0;
    #1;
    check("midrst_led", 32'(led_a), 0);
    tick();
    reset = 1'b1;
    repeat (3) tick();
    check("midrst_acc", acc_n, 0);
    check("midrst_rej", rej_n, 0);
    read("midrst_tally1", 4'b0010, 0, 0);
    read("midrst_tally2", 4'b0100, 0, 0);
    clear_counts();
    vote(4'b0001);
    check("postrst_acc", acc_n, 1);
    check("postrst_latency", first_acc, 10);
    read("postrst_tally0", 4'b0001, 1, 1);

    // Saturation on the CNT_W=2 instance
    clear_counts();
    for (int v = 0; v < 3; v++) vote(4'b1000);
    check("sat3_acc_b", sacc_n, 3);
    check("sat3_rej_b", srej_n, 0);
    clear_counts();
    vote(4'b1000);
    check("sat4_acc_b", sacc_n, 0);
    check("sat4_rej_b", srej_n, 1);
    check("sat4_acc_a", acc_n, 1);
    read("sat_tally3", 4'b1000, 4, 3);

`ifdef PVM_TOTAL_EN
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    clear_counts();
    vote(4'b0001);
    vote(4'b0100);
    vote(4'b1000);
    check("tot_acc", acc_n, 3);
    mode   = 1'b1;
    button = 4'b0000;
    tick();
    tick();
    check("tot_led_a", 32'(led_a), 3);
    check("tot_led_b", 32'(led_b), 3);
    check("tot_total_a", 32'(total_a), 3);
    check("tot_total_b", 32'(total_b), 3);
    mode = 1'b0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule

// File: doc/param_voting_machine.md
# param_voting_machine

Parametrised successor to the four-button voting machine. It supports NUM_CAND candidate buttons and a configurable hold-time vote qualifier. A vote counts only when exactly one button is held, and a second vote needs a full release first. Multi-press and overflow votes are rejected, and display mode reads back any tally. It sits between the panel's button inputs and the LED display.

## Interface
- NUM_CAND, 4: number of candidates/buttons, 2..16
- CNT_W, 8: tally width per candidate
- HOLD_CYCLES, 10: consecutive sampled cycles a single button must be held to cast a vote, 1..2^16-1
- LED_W, 8: display width
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- mode  in  1  0 = voting, 1 = display
- button  in  NUM_CAND  candidate buttons, bit i = candidate i
- led  out  LED_W  registered display value
- vote_accepted  out  1  one-cycle pulse when a tally increments
- vote_rejected  out  1  one-cycle pulse on a multi-press or saturated vote

## Operation
- Inputs are registered once each edge into button_q and mode_q. All decisions use the registered copies.
- FSM states: IDLE, ARMED, WAIT_REL.
- IDLE: if mode_q=0 and button_q is one-hot, go to ARMED, latch the index, hold_cnt=1.
  - If mode_q=0 and two or more bits are set, pulse vote_rejected and go to WAIT_REL.
- ARMED: while button_q is unchanged and mode_q=0, hold_cnt increments.
  - When hold_cnt reaches HOLD_CYCLES and tally[idx] < 2^CNT_W-1: increment tally, pulse vote_accepted, go to WAIT_REL.
  - When hold_cnt reaches HOLD_CYCLES and tally[idx] is saturated: tally is unchanged, pulse vote_rejected, go to WAIT_REL.
  - Release before the threshold: return to IDLE, no pulse.
  - Extra button joins: pulse vote_rejected, go to WAIT_REL.
  - mode_q goes to 1: go to WAIT_REL silently.
- WAIT_REL: stay until button_q == 0, then go to IDLE.
- Tallies never wrap.
- Display, mode_q=1: led = tally of the lowest-index set bit of button_q, zero-extended or truncated to LED_W.
  - If no bit is set, led = 0.
  - FSM stays in or enters WAIT_REL; no votes are counted in display mode.
- Display, mode_q=0: led = 0.

## Timing
- Reset values: led=0, vote_accepted=0, vote_rejected=0, all tallies=0, state=IDLE, hold_cnt=0.
- Vote latency: a button first sampled at edge 0 gives tally increment and vote_accepted high after edge HOLD_CYCLES.
  - Example: HOLD_CYCLES=10 gives a pulse 11 edges after the press reaches clk.
- Pulses last exactly one cycle. At most one pulse per press episode.
- led follows the registered inputs: it updates on the edge after button_q/mode_q change, 2 edges after the input pin.
- Reset asserted mid-hold aborts the vote; no pulse; all tallies cleared.
- Mode and button changing on the same edge: the mode_q rule takes priority.

## Configuration
- PVM_TOTAL_EN defined:
  - Adds output `total` with width CNT_W+$clog2(NUM_CAND).
  - `total` = registered sum of accepted votes, updated on the same edge as vote_accepted, reset 0.
  - In mode_q=1 with no button set, led shows `total` (truncated to LED_W) instead of 0.
- PVM_TOTAL_EN undefined: no `total` port, no adder, and display behaviour is exactly as in Operation.

## Structure
- Package pvm_pkg holds:
  - state enum {IDLE, ARMED, WAIT_REL}
  - one-hot check function
  - lowest-set-bit index function
  - default parameter constants
- Sub-module pvm_hold_timer: hold counter with clear/enable inputs and a `reached` output at HOLD_CYCLES. The width is derived via $clog2(HOLD_CYCLES+1).
- Top level holds the input registers, FSM, tally array, saturation check and display mux.

## Test plan
- Defaults, 10 ns clk. Hold button[1] for 200 ns → exactly one vote_accepted pulse 11 edges after the press. tally[1]=1. Reading in mode=1 with button[1] → led=1.
- Hold button[2] for 5 cycles then release → no pulse. tally[2]=0. A following 20-cycle press → tally[2]=1.
- Press button[1] and button[2] together for 200 ns → one vote_rejected pulse, tallies unchanged. A re-vote is only accepted after full release.
- CNT_W=2: four full votes on button[3] → tally[3]=3. The 4th press gives vote_rejected, not vote_accepted.
- Hold button[0] for 5 cycles, then pull reset low for 1 cycle → no pulse, all tallies 0, led=0. The next vote is counted normally.
- With PVM_TOTAL_EN: 3 votes spread over candidates 0, 2 and 3, then mode=1 with no button → led=3 and total=3.
